// File: rtl/wishbone_regfile_slave.sv
// -----------------------------------------------------------------------------
// wishbone_regfile_slave
//   Wishbone classic-cycle slave holding a bank of DEPTH control/status
//   registers. It supports byte-lane write selects and a configurable number of
//   wait states. Unmapped addresses get an error termination. A master that
//   drops cyc before the response gets a clean abort.
//
// Ports
//   clk       in   1         clock, all logic on the rising edge
//   rst       in   1         synchronous active-high reset
//   adr       in   ADDR_W    word address
//   dat_mosi  in   DATA_W    write data (master -> slave)
//   dat_miso  out  DATA_W    read data (slave -> master), registered
//   sel       in   DATA_W/8  byte-lane select, bit i covers [8i+7:8i]
//   we        in   1         1 = write, 0 = read
//   cyc       in   1         bus cycle valid
//   stb       in   1         transfer request
//   ack       out  1         normal termination, one-cycle registered pulse
//   err       out  1         error termination, one-cycle registered pulse
//
// Timing
//   A request is sampled in IDLE at edge N. It passes through WAIT_CYCLES wait
//   states and then one RESP cycle. ack/err/dat_miso are registered at the edge
//   that leaves RESP, so they are visible in the cycle after edge
//   N+1+WAIT_CYCLES. That same cycle is an IDLE cycle, so a master that holds
//   cyc&stb gets a new transfer accepted at the next edge.
// -----------------------------------------------------------------------------
module wishbone_regfile_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 4,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     adr,
  input  logic [DATA_W-1:0]     dat_mosi,
  output logic [DATA_W-1:0]     dat_miso,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic                  we,
  input  logic                  cyc,
  input  logic                  stb,
  output logic                  ack,
  output logic                  err
);

  localparam int                LANES     = DATA_W / 8;
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit                HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]        WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  // Elaboration-time parameter legality checks.
  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
      $fatal(1, "wishbone_regfile_slave: DATA_W must be a multiple of 8 in 8..64");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $fatal(1, "wishbone_regfile_slave: DEPTH must be in 1..2**ADDR_W");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $fatal(1, "wishbone_regfile_slave: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  // Request copies latched in IDLE; bus inputs are ignored until the next IDLE.
  logic [ADDR_W-1:0]   adr_r;
  logic [DATA_W-1:0]   dat_r;
  logic [LANES-1:0]    sel_r;
  logic                we_r;
  logic [3:0]          wcnt_r;

  logic                accept_s;
  logic                resp_ack_s;
  logic                resp_err_s;
  logic                commit_s;
  logic                mapped_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   rd_word_s;

  logic [DATA_W-1:0]   regs_r [DEPTH];

  // Address decode of the latched request.
  assign mapped_s = ({1'b0, adr_r} < DEPTH_L);
  assign idx_s    = adr_r[IDX_W-1:0];

  // Read data of the latched address; unmapped addresses read as zero.
  always_comb begin
    rd_word_s = '0;
    if (mapped_s) begin
      rd_word_s = regs_r[idx_s];
    end else begin
      rd_word_s = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; dropping cyc during WAIT aborts back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cyc && stb) begin
          state_nxt_s = HAS_WAIT ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!cyc) begin
          state_nxt_s = ST_IDLE;
        end else if (wcnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode. The RESP cycle decides ack/err/commit; these are
  // registered at the edge that leaves RESP. A master that has already
  // dropped cyc by then gets neither a response nor a write.
  always_comb begin
    accept_s   = 1'b0;
    resp_ack_s = 1'b0;
    resp_err_s = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cyc && stb) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_RESP: begin
        if (cyc && mapped_s) begin
          resp_ack_s = 1'b1;
          commit_s   = we_r;
        end else if (cyc) begin
          resp_err_s = 1'b1;
        end else begin
          resp_ack_s = 1'b0;
          resp_err_s = 1'b0;
        end
      end
      ST_WAIT: begin
        accept_s = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_r  <= '0;
      dat_r  <= '0;
      sel_r  <= '0;
      we_r   <= 1'b0;
      wcnt_r <= 4'd0;
    end else if (accept_s) begin
      adr_r  <= adr;
      dat_r  <= dat_mosi;
      sel_r  <= sel;
      we_r   <= we;
      wcnt_r <= WAIT_LOAD;
    end else if (state_r == ST_WAIT && wcnt_r != 4'd0) begin
      wcnt_r <= wcnt_r - 4'd1;
    end
  end

  // Registered bus responses. During a write ack dat_miso returns the
  // pre-write word, because rd_word_s still shows the old register value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= 1'b0;
      err      <= 1'b0;
      dat_miso <= '0;
    end else begin
      ack <= resp_ack_s;
      err <= resp_err_s;
      if (resp_ack_s) begin
        dat_miso <= rd_word_s;
      end else if (resp_err_s) begin
        dat_miso <= '0;
      end
    end
  end

  // Register bank with per-byte-lane write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else if (commit_s) begin
      for (int l = 0; l < LANES; l++) begin
        if (sel_r[l]) begin
          regs_r[idx_s][8*l +: 8] <= dat_r[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_regfile_slave.sv
// -----------------------------------------------------------------------------
// Self-checking bench for wishbone_regfile_slave.
//   dut0: default parameters (16 regs, no wait states, reset value 0)
//   dut1: 12 regs, 3 wait states, non-zero reset value
// Each transfer pushes its expected termination, data and latency to a
// scoreboard queue. The entry is popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_wishbone_regfile_slave;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          DEPTH1 = 12;
  localparam int          WAIT1  = 3;
  localparam logic [31:0] RV1    = 32'hA5A5_5A5A;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst   [2];
  logic [AW-1:0]  adr   [2];
  logic [DW-1:0]  dmosi [2];
  logic [DW-1:0]  dmiso [2];
  logic [3:0]     sel   [2];
  logic           we    [2];
  logic           cyc   [2];
  logic           stb   [2];
  logic           ack   [2];
  logic           err   [2];

  exp_t           sb [$];
  logic [31:0]    mem [2][16];
  int             depth_c [2];
  int             wait_c  [2];
  logic [31:0]    rv_c    [2];
  int             total = 0;
  int             bad   = 0;

  always #5 clk = ~clk;

  wishbone_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .WAIT_CYCLES(0), .RESET_VAL(32'h0)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .adr(adr[0]), .dat_mosi(dmosi[0]), .dat_miso(dmiso[0]),
    .sel(sel[0]), .we(we[0]), .cyc(cyc[0]), .stb(stb[0]), .ack(ack[0]), .err(err[0])
  );

  wishbone_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH1), .WAIT_CYCLES(WAIT1), .RESET_VAL(RV1)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .adr(adr[1]), .dat_mosi(dmosi[1]), .dat_miso(dmiso[1]),
    .sel(sel[1]), .we(we[1]), .cyc(cyc[1]), .stb(stb[1]), .ack(ack[1]), .err(err[1])
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < 16; i++) mem[d][i] = rv_c[d];
  endtask

  task automatic idle(input int d, input int n);
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One transfer, called at a negedge. It returns at the negedge where the
  // response is visible. The request inputs are scrambled once the request is
  // accepted, so the transfer must use its latched copies.
  task automatic xfer(input int d, input logic w, input logic [3:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input bit hold,
                      input string name, output logic [31:0] got);
    exp_t e;
    exp_t p;
    int   k;
    bit   seen;
    e.is_err = (int'(a) >= depth_c[d]);
    e.data   = e.is_err ? 32'h0 : mem[d][a];
    e.lat    = 1 + wait_c[d];
    e.name   = name;
    sb.push_back(e);
    if (!e.is_err && w) mem[d][a] = merge(mem[d][a], wd, s);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dmosi[d] = wd; sel[d] = s;
    @(posedge clk);
    #1;
    adr[d] = ~a; dmosi[d] = ~wd; sel[d] = ~s; we[d] = ~w;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (ack[d] || err[d]) seen = 1'b1;
    end
    p = sb.pop_front();
    got = dmiso[d];
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s timeout: no ack/err within %0d cycles", p.name, k);
    end else begin
      total++;
      if (ack[d] !== !p.is_err) begin
        bad++; $display("FAIL %s ack: got %b want %b", p.name, ack[d], !p.is_err);
      end
      total++;
      if (err[d] !== p.is_err) begin
        bad++; $display("FAIL %s err: got %b want %b", p.name, err[d], p.is_err);
      end
      total++;
      if (dmiso[d] !== p.data) begin
        bad++; $display("FAIL %s dat_miso: got %h want %h", p.name, dmiso[d], p.data);
      end
      total++;
      if (k !== p.lat) begin
        bad++; $display("FAIL %s latency: got %0d want %0d", p.name, k, p.lat);
      end
    end
    if (!hold) begin
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dmiso[d] !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got ack=%b err=%b dat=%h want 0 0 0",
                 d, ack[d], err[d], dmiso[d]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
  endtask

  task automatic test_basic_rw();
    logic [31:0] got;
    xfer(0, 1'b0, 4'd3, 32'h0, 4'hF, 1'b0, "rd3_after_reset", got);
    xfer(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, "wr3", got);
    idle(0, 1);
    xfer(0, 1'b0, 4'd3, 32'h0, 4'h0, 1'b0, "rd3", got);
    total++;
    if (got !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL rd3_value: got %h want deadbeef", got);
    end
    @(negedge clk);
    total++;
    if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin
      bad++; $display("FAIL ack_pulse_width: got ack=%b err=%b want 0 0", ack[0], err[0]);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] got;
    xfer(0, 1'b1, 4'd5, 32'h1122_3344, 4'hF, 1'b0, "wr5_full", got);
    xfer(0, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, "wr5_lanes", got);
    xfer(0, 1'b0, 4'd5, 32'h0, 4'hF, 1'b0, "rd5_lanes", got);
    total++;
    if (got !== 32'h11BB_33DD) begin
      bad++; $display("FAIL byte_lane_merge: got %h want 11bb33dd", got);
    end
    xfer(0, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'h0, 1'b0, "wr5_sel0", got);
    xfer(0, 1'b0, 4'd5, 32'h0, 4'hF, 1'b0, "rd5_sel0", got);
    total++;
    if (got !== 32'h11BB_33DD) begin
      bad++; $display("FAIL sel0_no_change: got %h want 11bb33dd", got);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] got;
    xfer(1, 1'b1, 4'd5, 32'h0F0F_0F0F, 4'hF, 1'b0, "d1_wr5", got);
    xfer(1, 1'b1, 4'd13, 32'h7777_7777, 4'hF, 1'b0, "d1_wr13_err", got);
    xfer(1, 1'b0, 4'd13, 32'h0, 4'hF, 1'b0, "d1_rd13_err", got);
    xfer(1, 1'b0, 4'd11, 32'h0, 4'hF, 1'b0, "d1_rd11_last", got);
    xfer(1, 1'b0, 4'd12, 32'h0, 4'hF, 1'b0, "d1_rd12_first_unmapped", got);
    xfer(1, 1'b0, 4'd5, 32'h0, 4'hF, 1'b0, "d1_rd5", got);
    total++;
    if (got !== 32'h0F0F_0F0F) begin
      bad++; $display("FAIL unmapped_no_side_effect: got %h want 0f0f0f0f", got);
    end
    xfer(1, 1'b0, 4'd1, 32'h0, 4'hF, 1'b0, "d1_rd1", got);
  endtask

  task automatic test_wait_states();
    logic [31:0] got;
    bit          resp;
    xfer(1, 1'b1, 4'd2, 32'h55AA_55AA, 4'hF, 1'b0, "d1_wr2", got);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 4'd2;
    dmosi[1] = 32'h0BAD_F00D; sel[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    resp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) resp = 1'b1;
    end
    total++;
    if (resp !== 1'b0) begin
      bad++; $display("FAIL abort_no_response: got response=1 want 0");
    end
    xfer(1, 1'b0, 4'd2, 32'h0, 4'hF, 1'b0, "d1_rd2_after_abort", got);
    total++;
    if (got !== 32'h55AA_55AA) begin
      bad++; $display("FAIL abort_no_write: got %h want 55aa55aa", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    bit          resp;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 4'd1;
    dmosi[1] = 32'h1234_5678; sel[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    total++;
    if (dmiso[1] !== 32'h0) begin
      bad++; $display("FAIL mid_reset_dat_miso: got %h want 0", dmiso[1]);
    end
    resp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) resp = 1'b1;
    end
    total++;
    if (resp !== 1'b0) begin
      bad++; $display("FAIL mid_reset_no_ack: got response=1 want 0");
    end
    xfer(1, 1'b0, 4'd1, 32'h0, 4'hF, 1'b0, "d1_rd1_after_reset", got);
    total++;
    if (got !== RV1) begin
      bad++; $display("FAIL mid_reset_reg1: got %h want %h", got, RV1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    time         t0;
    t0 = $time;
    for (int r = 0; r < 2; r++) begin
      xfer(0, 1'b1, 4'd0, 32'hCAFE_BABE, 4'hF, 1'b1, "b2b_wr0", got);
      xfer(0, 1'b0, 4'd0, 32'h0, 4'hF, 1'b1, "b2b_rd0", got);
      total++;
      if (got !== 32'hCAFE_BABE) begin
        bad++; $display("FAIL b2b_rd0_value: got %h want cafebabe", got);
      end
      xfer(0, 1'b1, 4'd2, 32'h0000_0001, 4'hF, 1'b1, "b2b_wr2", got);
      xfer(0, 1'b0, 4'd2, 32'h0, 4'hF, (r == 0), "b2b_rd2", got);
      total++;
      if (got !== 32'h0000_0001) begin
        bad++; $display("FAIL b2b_rd2_value: got %h want 00000001", got);
      end
    end
    total++;
    if (($time - t0) !== 160) begin
      bad++; $display("FAIL b2b_throughput: got %0t time units want 160", $time - t0);
    end
    idle(0, 2);
  endtask

  initial begin
    depth_c[0] = 16;     depth_c[1] = DEPTH1;
    wait_c[0]  = 0;      wait_c[1]  = WAIT1;
    rv_c[0]    = 32'h0;  rv_c[1]    = RV1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; adr[d] = '0; dmosi[d] = '0; sel[d] = '0;
      we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_unmapped();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
